// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receive path.
//   i2c_rx_state_t    : receiver FSM states
//   I2C_BITS_PER_BYTE : bits per bus byte (address+rw or data)
//   I2C_BIT_CNT_W     : width of the in-byte bit counter
package i2c_pkg;

    localparam int unsigned I2C_BITS_PER_BYTE = 8;
    localparam int unsigned I2C_BIT_CNT_W     = $clog2(I2C_BITS_PER_BYTE);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_rx_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning: synchronises SCL/SDA, detects SCL edges and START/STOP.
//   clk, rst          : system clock, synchronous active-high reset
//   i2c_scl, i2c_sda  : raw pad inputs
//   scl_rise/scl_fall : one-cycle strobes on synced SCL edges
//   sda_s             : synced SDA level
//   start/stop        : one-cycle strobes on START / STOP conditions
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i2c_scl,
    input  logic i2c_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Preset to 1 (idle bus) so leaving reset never looks like an edge or START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // SDA moving while SCL is stable high marks START (falling) or STOP (rising).
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_recv.sv
// I2C target write receiver: address match, data shift-in, ACK/NACK drive, valid/ready output.
//   clk, rst          : system clock, synchronous active-high reset
//   i2c_scl, i2c_sda  : bus pad inputs
//   sda_oe            : 1 pulls SDA low (ACK), 0 releases
//   rx_data/rx_valid  : received byte and its valid flag
//   rx_ready          : downstream consume strobe (with rx_valid)
//   bus_start/stop    : one-cycle pulses on START / STOP
//   overrun           : sticky, a data byte was NACKed because rx_data was still full
module i2c_slave_recv
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h3C,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       bus_start,
    output logic       bus_stop,
    output logic       overrun
);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start;
    logic stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .sda_s   (sda_s),
        .start   (start),
        .stop    (stop)
    );

    i2c_rx_state_t                  state, state_n;
    logic [I2C_BIT_CNT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [I2C_BITS_PER_BYTE-1:0]   shift, shift_n;
    logic                           byte_full, byte_full_n;
    logic                           sda_oe_n;
    logic [7:0]                     rx_data_n;
    logic                           rx_valid_n;
    logic                           overrun_n;

    // Registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_full <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            bus_start <= 1'b0;
            bus_stop  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            byte_full <= byte_full_n;
            sda_oe    <= sda_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            overrun   <= overrun_n;
            bus_start <= start;
            bus_stop  <= stop;
        end
    end

    // Next state, shift/count and handshake.
    // byte_full marks that 8 bits arrived; bit_cnt alone cannot tell "wrapped" from "fresh".
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        byte_full_n = byte_full;
        sda_oe_n    = sda_oe;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid & ~rx_ready;
        overrun_n   = overrun;

        if (start) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            byte_full_n = 1'b0;
            sda_oe_n    = 1'b0;
        end else if (stop) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            byte_full_n = 1'b0;
            sda_oe_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_oe_n = 1'b0;
                end
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[I2C_BITS_PER_BYTE-2:0], sda_s};
                        bit_cnt_n = bit_cnt + I2C_BIT_CNT_W'(1);
                        if (bit_cnt == I2C_BIT_CNT_W'(I2C_BITS_PER_BYTE - 1))
                            byte_full_n = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_n = 1'b0;
                        if (state == ADDR) begin
                            // Only writes to our address are acknowledged.
                            if (shift[7:1] == SLV_ADDR && !shift[0]) begin
                                state_n  = ADDR_ACK;
                                sda_oe_n = 1'b1;
                            end else begin
                                state_n  = IGNORE;
                                sda_oe_n = 1'b0;
                            end
                        end else if (!rx_valid || rx_ready) begin
                            state_n    = DATA_ACK;
                            sda_oe_n   = 1'b1;
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                        end else begin
                            state_n   = IGNORE;
                            sda_oe_n  = 1'b0;
                            overrun_n = 1'b1;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        state_n   = DATA;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_recv.sv
// Bench for i2c_slave_recv: controller bus model with wired-AND SDA and a byte scoreboard.
module tb_i2c_slave_recv;

    logic       clk;
    logic       rst;
    logic       scl_bus;
    logic       ctrl_low;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       bus_start;
    logic       bus_stop;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_stop   = 0;
    int n_rise   = 0;
    bit oe_seen  = 0;
    bit prev_valid = 0;
    logic [7:0] exp_q[$];

    assign sda_bus = (ctrl_low | sda_oe) ? 1'b0 : 1'b1;

    i2c_slave_recv #(
        .SLV_ADDR   (7'h3C),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (scl_bus),
        .i2c_sda  (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .bus_start(bus_start),
        .bus_stop (bus_stop),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pulse counters and scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_start) n_start++;
            if (bus_stop) n_stop++;
            if (sda_oe) oe_seen = 1;
            if (rx_valid && !prev_valid) n_rise++;
            prev_valid = rx_valid;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0)
                    check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
                else
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        ctrl_low = 1'b1; wait_clk(4);
        scl_bus  = 1'b0; wait_clk(4);
    endtask

    task automatic rstart_cond();
        ctrl_low = 1'b0; wait_clk(4);
        scl_bus  = 1'b1; wait_clk(4);
        ctrl_low = 1'b1; wait_clk(4);
        scl_bus  = 1'b0; wait_clk(4);
    endtask

    task automatic stop_cond();
        ctrl_low = 1'b1; wait_clk(4);
        scl_bus  = 1'b1; wait_clk(4);
        ctrl_low = 1'b0; wait_clk(4);
    endtask

    task automatic send_bit(input logic b);
        ctrl_low = ~b;   wait_clk(4);
        scl_bus  = 1'b1; wait_clk(8);
        scl_bus  = 1'b0; wait_clk(4);
    endtask

    // Returns the bus SDA level mid-way through the 9th clock (0 = ACK).
    task automatic ack_slot(output logic ack);
        ctrl_low = 1'b0; wait_clk(4);
        scl_bus  = 1'b1; wait_clk(4);
        ack      = sda_bus; wait_clk(4);
        scl_bus  = 1'b0; wait_clk(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(ack);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic clr_counts();
        n_start = 0; n_stop = 0; n_rise = 0; oe_seen = 0;
    endtask

    logic ack;

    initial begin
        rst = 1'b1; scl_bus = 1'b1; ctrl_low = 1'b0; rx_ready = 1'b1;
        wait_clk(4);
        check("rst_sda_oe",    32'(sda_oe),    32'd0);
        check("rst_rx_data",   32'(rx_data),   32'd0);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_bus_start", 32'(bus_start), 32'd0);
        check("rst_bus_stop",  32'(bus_stop),  32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        rst = 1'b0;
        wait_clk(8);

        // T1: write two bytes to our address.
        clr_counts();
        start_cond();
        send_byte(8'h78, ack); check("t1_addr_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 32'd0);
        stop_cond();
        wait_clk(8);
        check("t1_valid_cnt", 32'(n_rise),  32'd2);
        check("t1_start_cnt", 32'(n_start), 32'd1);
        check("t1_stop_cnt",  32'(n_stop),  32'd1);
        check("t1_q_empty",   32'(exp_q.size()), 32'd0);

        // T2: address miss.
        clr_counts();
        start_cond();
        send_byte(8'h7A, ack); check("t2_addr_nack", 32'(ack), 32'd1);
        send_byte(8'h11, ack); check("t2_data_nack", 32'(ack), 32'd1);
        stop_cond();
        wait_clk(8);
        check("t2_oe_seen", 32'(oe_seen), 32'd0);
        check("t2_valid",   32'(n_rise),  32'd0);

        // T3: read request to our address is NACKed and the rest ignored.
        clr_counts();
        start_cond();
        send_byte(8'h79, ack); check("t3_addr_nack", 32'(ack), 32'd1);
        send_byte(8'h55, ack); check("t3_data_nack", 32'(ack), 32'd1);
        stop_cond();
        wait_clk(8);
        check("t3_oe_seen", 32'(oe_seen), 32'd0);
        check("t3_valid",   32'(n_rise),  32'd0);

        // T4: backpressure, second byte overruns.
        clr_counts();
        set_ready(1'b0);
        start_cond();
        send_byte(8'h78, ack); check("t4_addr_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'h01);
        send_byte(8'h01, ack); check("t4_d0_ack", 32'(ack), 32'd0);
        send_byte(8'h02, ack); check("t4_d1_nack", 32'(ack), 32'd1);
        check("t4_overrun",  32'(overrun),  32'd1);
        check("t4_rx_data",  32'(rx_data),  32'h01);
        check("t4_rx_valid", 32'(rx_valid), 32'd1);
        stop_cond();
        set_ready(1'b1);
        wait_clk(8);
        check("t4_q_empty",  32'(exp_q.size()), 32'd0);
        check("t4_rx_clear", 32'(rx_valid),     32'd0);
        check("t4_ovr_sticky", 32'(overrun),    32'd1);

        // T5: repeated START between two writes.
        clr_counts();
        start_cond();
        send_byte(8'h78, ack); check("t5_a0_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, ack); check("t5_d0_ack", 32'(ack), 32'd0);
        rstart_cond();
        send_byte(8'h78, ack); check("t5_a1_ack", 32'(ack), 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, ack); check("t5_d1_ack", 32'(ack), 32'd0);
        stop_cond();
        wait_clk(8);
        check("t5_start_cnt", 32'(n_start), 32'd2);
        check("t5_stop_cnt",  32'(n_stop),  32'd1);
        check("t5_valid_cnt", 32'(n_rise),  32'd2);
        check("t5_q_empty",   32'(exp_q.size()), 32'd0);

        // T6: reset during the address ACK, then a byte without START.
        clr_counts();
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'h78;
            send_bit(a[i]);
        end
        check("t6_oe_before", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("t6_oe_after_rst", 32'(sda_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_slot(ack); check("t6_ack_released", 32'(ack), 32'd1);
        clr_counts();
        send_byte(8'h99, ack); check("t6_byte_nack", 32'(ack), 32'd1);
        stop_cond();
        wait_clk(8);
        check("t6_oe_seen",  32'(oe_seen),  32'd0);
        check("t6_valid",    32'(n_rise),   32'd0);
        check("t6_overrun",  32'(overrun),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
